// File: rtl/gate_vector_sequencer_pkg.sv
// rtl/gate_vector_sequencer_pkg.sv - shared constants and state type for the gate vector sequencer
package gate_test_pkg;

  localparam int AND_BIT  = 0;
  localparam int OR_BIT   = 1;
  localparam int NOT_BIT  = 2;
  localparam int NAND_BIT = 3;
  localparam int NOR_BIT  = 4;
  localparam int XOR_BIT  = 5;
  localparam int XNOR_BIT = 6;

  localparam int NUM_VECTORS = 4;
  localparam int NUM_GATES   = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/gate_vector_sequencer_if.sv
// rtl/gate_vector_sequencer_if.sv - sequencer control/result and gate-block signals
interface gate_vector_sequencer_if;
  import gate_test_pkg::*;

  logic                   start;
  logic                   a;
  logic                   b;
  logic [NUM_GATES-1:0]   gate_out;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [NUM_VECTORS-1:0] err_mask;
  logic [NUM_GATES-1:0]   fail_bits;

  modport master (
    input  start, gate_out,
    output a, b, busy, done, pass, err_mask, fail_bits
  );

  modport slave (
    output start, gate_out,
    input  a, b, busy, done, pass, err_mask, fail_bits
  );

endinterface

// File: rtl/gate_vector_sequencer_golden_model.sv
// rtl/gate_vector_sequencer_golden_model.sv - expected outputs of the two-input basic-gate block
module gate_golden_model
  import gate_test_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] expected
);

  always_comb begin
    expected           = '0;
    expected[AND_BIT]  = a & b;
    expected[OR_BIT]   = a | b;
    expected[NOT_BIT]  = ~a;
    expected[NAND_BIT] = ~(a & b);
    expected[NOR_BIT]  = ~(a | b);
    expected[XOR_BIT]  = a ^ b;
    expected[XNOR_BIT] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// rtl/gate_vector_sequencer.sv - walks a/b through 00..11, samples gate outputs, reports mismatches
module gate_vector_sequencer
  import gate_test_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  gate_vector_sequencer_if.master  bus
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HCNT_RELOAD = HCW'(HOLD_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [1:0]             vec_q, vec_d;
  logic [HCW-1:0]         hcnt_q, hcnt_d;
  logic                   a_q, a_d;
  logic                   b_q, b_d;
  logic                   pass_q, pass_d;
  logic [NUM_VECTORS-1:0] err_q, err_d;
  logic [NUM_GATES-1:0]   fail_q, fail_d;

  logic [NUM_GATES-1:0]   golden;
  logic [NUM_GATES-1:0]   mismatch;

  // Golden is driven from the registered a/b so it matches what the gate block sees.
  gate_golden_model u_golden (
    .a        (a_q),
    .b        (b_q),
    .expected (golden)
  );

  assign mismatch = golden ^ bus.gate_out;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hcnt_d  = hcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        a_d     = 1'b0;
        b_d     = 1'b0;
        state_d = ST_IDLE;
        if (bus.start) begin
          state_d = ST_APPLY;
          vec_d   = 2'd0;
          hcnt_d  = HCNT_RELOAD;
          pass_d  = 1'b0;
          err_d   = '0;
          fail_d  = '0;
        end
      end

      ST_APPLY: begin
        if (hcnt_q != '0) begin
          hcnt_d = hcnt_q - HCW'(1);
        end else begin
          fail_d = fail_q | mismatch;
          if (|mismatch) begin
            err_d[vec_q] = 1'b1;
          end
          if (vec_q == 2'd3) begin
            // Results land together with the move to FINISH so they are valid during done.
            state_d = ST_FINISH;
            pass_d  = ((fail_q | mismatch) == '0);
            a_d     = 1'b0;
            b_d     = 1'b0;
          end else begin
            vec_d      = vec_q + 2'd1;
            {a_d, b_d} = vec_q + 2'd1;
            hcnt_d     = HCNT_RELOAD;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= 2'd0;
      hcnt_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hcnt_q  <= hcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = (state_q == ST_APPLY);
  assign bus.done      = (state_q == ST_FINISH);
  assign bus.pass      = pass_q;
  assign bus.err_mask  = err_q;
  assign bus.fail_bits = fail_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// tb/tb_gate_vector_sequencer.sv - directed bench for gate_vector_sequencer with H=4 and H=1
module tb_gate_vector_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic xor_fault = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   done_cnt0 = 0;
  int   cnt_before;

  always #5 clk = ~clk;

  gate_vector_sequencer_if bus0 ();
  gate_vector_sequencer_if bus1 ();

  gate_vector_sequencer #(.HOLD_CYCLES(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  gate_vector_sequencer #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Bench-side gate block, order and,or,not,nand,nor,xor,xnor from bit0.
  assign bus0.gate_out = {~(bus0.a ^ bus0.b), (bus0.a ^ bus0.b) & ~xor_fault, ~(bus0.a | bus0.b),
                          ~(bus0.a & bus0.b), ~bus0.a, bus0.a | bus0.b, bus0.a & bus0.b};
  assign bus1.gate_out = {~(bus1.a ^ bus1.b), bus1.a ^ bus1.b, ~(bus1.a | bus1.b),
                          ~(bus1.a & bus1.b), ~bus1.a, bus1.a | bus1.b, bus1.a & bus1.b};

  always @(posedge clk) if (bus0.done === 1'b1) done_cnt0 <= done_cnt0 + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; one full H=4 run on dut0 ending at the negedge of the done cycle.
  task automatic run0(input bit hold_start, input bit restart5, input logic exp_pass,
                      input logic [3:0] exp_err, input logic [6:0] exp_fail);
    bus0.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus0.start = hold_start || (restart5 && k == 5);
      chk("busy_run", bus0.busy, 1);
      chk("vec_ab", {bus0.a, bus0.b}, k / 4);
      chk("done_low", bus0.done, 0);
      if (k == 0) begin
        chk("clr_pass", bus0.pass, 0);
        chk("clr_err", bus0.err_mask, 0);
        chk("clr_fail", bus0.fail_bits, 0);
      end
    end
    @(negedge clk);
    chk("done_pulse", bus0.done, 1);
    chk("busy_fin", bus0.busy, 0);
    chk("ab_fin", {bus0.a, bus0.b}, 0);
    chk("pass", bus0.pass, exp_pass);
    chk("err_mask", bus0.err_mask, exp_err);
    chk("fail_bits", bus0.fail_bits, exp_fail);
  endtask

  initial begin
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    @(negedge clk);
    chk("rst_a", bus0.a, 0);
    chk("rst_b", bus0.b, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_pass", bus0.pass, 0);
    chk("rst_err", bus0.err_mask, 0);
    chk("rst_fail", bus0.fail_bits, 0);
    rst = 1'b0;
    @(negedge clk);

    // Correct gate block, single start pulse
    cnt_before = done_cnt0;
    run0(0, 0, 1'b1, 4'b0000, 7'b0000000);
    @(negedge clk);
    chk("done_once", done_cnt0, cnt_before + 1);
    chk("done_drop", bus0.done, 0);
    chk("pass_hold", bus0.pass, 1);

    // XOR output stuck at 0
    xor_fault = 1'b1;
    run0(0, 0, 1'b0, 4'b0110, 7'b0100000);
    @(negedge clk);
    xor_fault = 1'b0;
    chk("err_hold", bus0.err_mask, 4'b0110);

    // Start reasserted mid-run is ignored
    cnt_before = done_cnt0;
    run0(0, 1, 1'b1, 4'b0000, 7'b0000000);
    @(negedge clk);
    chk("restart_one_done", done_cnt0, cnt_before + 1);
    chk("restart_idle", bus0.busy, 0);

    // Reset while vector 10 is driven
    bus0.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus0.start = 1'b0;
    end
    chk("pre_rst_ab", {bus0.a, bus0.b}, 2'b10);
    cnt_before = done_cnt0;
    rst = 1'b1;
    #1;
    chk("mid_rst_a", bus0.a, 0);
    chk("mid_rst_b", bus0.b, 0);
    chk("mid_rst_busy", bus0.busy, 0);
    chk("mid_rst_done", bus0.done, 0);
    chk("mid_rst_pass", bus0.pass, 0);
    chk("mid_rst_err", bus0.err_mask, 0);
    chk("mid_rst_fail", bus0.fail_bits, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("no_done_after_rst", done_cnt0, cnt_before);
    run0(0, 0, 1'b1, 4'b0000, 7'b0000000);
    @(negedge clk);

    // Start held through done: back-to-back runs, first one faulty
    xor_fault = 1'b1;
    run0(1, 0, 1'b0, 4'b0110, 7'b0100000);
    xor_fault = 1'b0;
    run0(0, 0, 1'b1, 4'b0000, 7'b0000000);
    @(negedge clk);

    // H=1 on dut1
    bus1.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      chk("h1_busy", bus1.busy, 1);
      chk("h1_vec", {bus1.a, bus1.b}, k);
    end
    @(negedge clk);
    chk("h1_done", bus1.done, 1);
    chk("h1_busy_fin", bus1.busy, 0);
    chk("h1_pass", bus1.pass, 1);
    chk("h1_err", bus1.err_mask, 0);
    chk("h1_fail", bus1.fail_bits, 0);
    @(negedge clk);
    chk("h1_done_drop", bus1.done, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
